sort_iter_net: RTL and testbench

- Parametrised, iterative successor to the fixed 4-input 2-bit min/midl/midh/max sorter.
- Loads N words of W bits on a start pulse and sorts them in place by odd-even transposition, one phase per clock.
- Returns the sorted vector with a one-cycle done pulse. Adds a direction mode, signed/unsigned compare, optional early exit and a phase count.
- Intended as the reusable sort engine behind the lab sorter wrappers.

---
 rtl/sort_pkg.sv | 21 ++
 rtl/sort_cmp_swap.sv | 27 ++
 rtl/sort_iter_net.sv | 137 +++++++++++++
 tb/tb_sort_iter_net.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types, direction encodings and the width/sign-aware compare
// used by the iterative odd-even transposition sorter.
package sort_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SORT = 1'b1
    } state_e;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    // Operands arrive zero-extended; flipping bit w-1 maps two's complement onto unsigned order.
    function automatic logic gt(input logic [63:0] a, input logic [63:0] b,
                                input int unsigned w, input logic sgn);
        logic [63:0] flip;
        flip = 64'(sgn) << (w - 1);
        return (a ^ flip) > (b ^ flip);
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// One compare-exchange cell for an adjacent pair; passes the pair through when disabled.
module sort_cmp_swap
    import sort_pkg::*;
#(
    parameter int unsigned W      = 2,
    parameter bit          SIGNED = 1'b0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         dir,
    input  logic         en,
    output logic [W-1:0] lo_slot,
    output logic [W-1:0] hi_slot,
    output logic         swapped
);

    logic out_of_order;

    // Strict compare keeps equal values in place.
    assign out_of_order = (dir == DIR_ASC) ? gt(64'(a), 64'(b), W, SIGNED)
                                           : gt(64'(b), 64'(a), W, SIGNED);

    assign swapped = en & out_of_order;
    assign lo_slot = swapped ? b : a;
    assign hi_slot = swapped ? a : b;

endmodule

// File: rtl/sort_iter_net.sv
// Iterative N-element odd-even transposition sorter: one phase per clock,
// with direction select, signed compare and optional early exit.
module sort_iter_net
    import sort_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned W          = 2,
    parameter bit          SIGNED     = 1'b0,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     dir,
    input  logic [N*W-1:0]           data_in,
    output logic                     busy,
    output logic                     done,
    output logic [N*W-1:0]           data_out,
    output logic [$clog2(N+1)-1:0]   phases
);

    localparam int unsigned PW = $clog2(N + 1);
    localparam int unsigned NP = N - 1;

    state_e          state_q, state_d;
    logic [N*W-1:0]  work_q, work_d;
    logic            dir_q, dir_d;
    logic [PW-1:0]   p_q, p_d;
    logic            prev_zero_q, prev_zero_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N*W-1:0]  data_out_q, data_out_d;
    logic [PW-1:0]   phases_q, phases_d;

    logic [NP-1:0]   en;
    logic [NP-1:0]   swp;
    logic [W-1:0]    lo [NP];
    logic [W-1:0]    hi [NP];
    logic [N*W-1:0]  phase_res;
    logic            any_swap;
    logic            last_phase;

    // Pair i starts at slot i; even pairs run in even phases, odd pairs in odd phases.
    for (genvar i = 0; i < NP; i++) begin : g_pair
        assign en[i] = (p_q[0] == 1'(i % 2));
        sort_cmp_swap #(.W(W), .SIGNED(SIGNED)) u_cs (
            .a       (work_q[i*W +: W]),
            .b       (work_q[(i+1)*W +: W]),
            .dir     (dir_q),
            .en      (en[i]),
            .lo_slot (lo[i]),
            .hi_slot (hi[i]),
            .swapped (swp[i])
        );
    end

    always_comb begin
        phase_res = work_q;
        for (int i = 0; i < int'(NP); i++) begin
            if (en[i]) begin
                phase_res[i*W +: W]     = lo[i];
                phase_res[(i+1)*W +: W] = hi[i];
            end
        end
    end

    assign any_swap   = |swp;
    assign last_phase = (p_q == PW'(NP)) ||
                        (EARLY_EXIT && (p_q != '0) && !any_swap && prev_zero_q);

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        dir_d       = dir_q;
        p_d         = p_q;
        prev_zero_d = prev_zero_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        data_out_d  = data_out_q;
        phases_d    = phases_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d      = data_in;
                    dir_d       = dir;
                    p_d         = '0;
                    prev_zero_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_SORT;
                end
            end
            ST_SORT: begin
                work_d      = phase_res;
                p_d         = p_q + PW'(1);
                prev_zero_d = !any_swap;
                if (last_phase) begin
                    data_out_d = phase_res;
                    phases_d   = p_q + PW'(1);
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            dir_q       <= 1'b0;
            p_q         <= '0;
            prev_zero_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_out_q  <= '0;
            phases_q    <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            dir_q       <= dir_d;
            p_q         <= p_d;
            prev_zero_q <= prev_zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            data_out_q  <= data_out_d;
            phases_q    <= phases_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;
    assign phases   = phases_q;

endmodule

// File: tb/tb_sort_iter_net.sv
// Directed checks of sort_iter_net: default, signed and early-exit instances.
module tb_sort_iter_net;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_a = '0;
    logic       dir_l = 1'b0;
    logic [7:0] din = '0;

    logic [2:0] busy_a, done_a;
    logic [7:0] dout_a [3];
    logic [2:0] ph_a   [3];

    int total = 0;
    int passed = 0;
    int fails = 0;
    int lat, bcyc, ndone;

    always #5 clk = ~clk;

    sort_iter_net #(.N(4), .W(2), .SIGNED(1'b0), .EARLY_EXIT(1'b0)) u_def (
        .clk(clk), .rst(rst), .start(start_a[0]), .dir(dir_l), .data_in(din),
        .busy(busy_a[0]), .done(done_a[0]), .data_out(dout_a[0]), .phases(ph_a[0]));

    sort_iter_net #(.N(4), .W(2), .SIGNED(1'b1), .EARLY_EXIT(1'b0)) u_sgn (
        .clk(clk), .rst(rst), .start(start_a[1]), .dir(dir_l), .data_in(din),
        .busy(busy_a[1]), .done(done_a[1]), .data_out(dout_a[1]), .phases(ph_a[1]));

    sort_iter_net #(.N(4), .W(2), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst(rst), .start(start_a[2]), .dir(dir_l), .data_in(din),
        .busy(busy_a[2]), .done(done_a[2]), .data_out(dout_a[2]), .phases(ph_a[2]));

    function automatic logic [7:0] pk(input logic [1:0] e0, input logic [1:0] e1,
                                      input logic [1:0] e2, input logic [1:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start (optionally again mid-sort with junk inputs) and wait for done.
    task automatic do_sort(input int sel, input logic [7:0] d, input logic dr,
                           input int restart_at, output int lat_o, output int bcyc_o);
        din = d;
        dir_l = dr;
        start_a[sel] = 1'b1;
        @(posedge clk); #1;
        start_a[sel] = 1'b0;
        bcyc_o = busy_a[sel] ? 1 : 0;
        lat_o = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k == restart_at) begin
                start_a[sel] = 1'b1;
                din = 8'h55;
                dir_l = ~dr;
            end
            @(posedge clk); #1;
            start_a[sel] = 1'b0;
            if (done_a[sel]) begin
                lat_o = k;
                break;
            end
            if (busy_a[sel]) bcyc_o++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy",   32'(busy_a[0]),  32'd0);
        check("rst_done",   32'(done_a[0]),  32'd0);
        check("rst_dout",   32'(dout_a[0]),  32'd0);
        check("rst_phases", 32'(ph_a[0]),    32'd0);

        do_sort(0, pk(3, 1, 2, 0), 1'b0, 0, lat, bcyc);
        check("asc_lat",    32'(lat),        32'd4);
        check("asc_busy",   32'(bcyc),       32'd4);
        check("asc_busy0",  32'(busy_a[0]),  32'd0);
        check("asc_dout",   32'(dout_a[0]),  32'(pk(0, 1, 2, 3)));
        check("asc_phases", 32'(ph_a[0]),    32'd4);
        @(posedge clk); #1;
        check("done_pulse", 32'(done_a[0]),  32'd0);

        do_sort(0, pk(3, 1, 2, 0), 1'b1, 0, lat, bcyc);
        check("desc_dout",   32'(dout_a[0]), 32'(pk(3, 2, 1, 0)));
        check("desc_phases", 32'(ph_a[0]),   32'd4);

        do_sort(0, pk(2, 2, 0, 2), 1'b0, 0, lat, bcyc);
        check("dup_dout",    32'(dout_a[0]), 32'(pk(0, 2, 2, 2)));

        do_sort(1, pk(2'b01, 2'b10, 2'b00, 2'b11), 1'b0, 0, lat, bcyc);
        check("sgn_dout",    32'(dout_a[1]), 32'(pk(2'b10, 2'b11, 2'b00, 2'b01)));
        check("sgn_lat",     32'(lat),       32'd4);

        do_sort(2, pk(0, 1, 2, 3), 1'b0, 0, lat, bcyc);
        check("ee_sorted_lat",  32'(lat),       32'd2);
        check("ee_sorted_ph",   32'(ph_a[2]),   32'd2);
        check("ee_sorted_dout", 32'(dout_a[2]), 32'(pk(0, 1, 2, 3)));
        do_sort(2, pk(1, 0, 2, 3), 1'b0, 0, lat, bcyc);
        check("ee_one_lat",  32'(lat),       32'd3);
        check("ee_one_ph",   32'(ph_a[2]),   32'd3);
        check("ee_one_dout", 32'(dout_a[2]), 32'(pk(0, 1, 2, 3)));

        do_sort(0, pk(3, 1, 2, 0), 1'b0, 2, lat, bcyc);
        check("mid_start_lat",  32'(lat),       32'd4);
        check("mid_start_dout", 32'(dout_a[0]), 32'(pk(0, 1, 2, 3)));

        // Start again straight from the done cycle.
        do_sort(0, pk(3, 3, 3, 0), 1'b1, 0, lat, bcyc);
        do_sort(0, pk(2, 3, 0, 1), 1'b0, 0, lat, bcyc);
        check("b2b_lat",  32'(lat),       32'd4);
        check("b2b_dout", 32'(dout_a[0]), 32'(pk(0, 1, 2, 3)));

        din = pk(3, 0, 1, 2);
        dir_l = 1'b0;
        start_a[0] = 1'b1;
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_busy",   32'(busy_a[0]), 32'd0);
        check("arst_done",   32'(done_a[0]), 32'd0);
        check("arst_dout",   32'(dout_a[0]), 32'd0);
        check("arst_phases", 32'(ph_a[0]),   32'd0);
        #2 rst = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_a[0]) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);

        do_sort(0, pk(3, 0, 1, 2), 1'b0, 0, lat, bcyc);
        check("post_rst_lat",  32'(lat),       32'd4);
        check("post_rst_dout", 32'(dout_a[0]), 32'(pk(0, 1, 2, 3)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
